// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer slice.
//   - FSM state encoding
//   - song table entry layout {note, dur} and its special codes
//   - helper to build a table entry
package melody_sequencer_pkg;

    localparam int NOTE_W  = 8;
    localparam int DUR_W   = 8;
    localparam int ENTRY_W = NOTE_W + DUR_W;

    localparam logic [NOTE_W-1:0] REST_CODE = 8'd0;
    localparam logic [DUR_W-1:0]  END_DUR   = 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_NOTE,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } song_entry_t;

    function automatic song_entry_t mk_entry(input logic [NOTE_W-1:0] note,
                                             input logic [DUR_W-1:0]  dur);
        song_entry_t e;
        e.note = note;
        e.dur  = dur;
        return e;
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between a player controller (master) and the
// melody sequencer (slave).
//   start, stop, loop_en        : controller -> sequencer
//   note_code, play             : sequencer -> tone generator / controller
//   busy, done, note_idx        : sequencer status
interface melody_sequencer_if
    import melody_sequencer_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [NOTE_W-1:0] note_code;
    logic              play;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] note_idx;

    modport master (
        output start, stop, loop_en,
        input  note_code, play, busy, done, note_idx
    );

    modport slave (
        input  start, stop, loop_en,
        output note_code, play, busy, done, note_idx
    );

endinterface

// File: rtl/melody_rom.sv
// Song table, case-based, with a registered read port (data valid one cycle
// after the address changes). Unlisted addresses read as the end marker.
//   clk_i  : system clock
//   addr_i : table entry address
//   data_o : {note, dur}, registered
// SONG_SEL picks the table: 0 = demo song ending in an end marker,
// 1 = four-entry pattern with no end marker (relies on the table-end wrap).
module melody_rom
    import melody_sequencer_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int SONG_SEL = 0
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    output song_entry_t       data_o
);

    song_entry_t entry_d;
    song_entry_t data_q;

    always_comb begin
        entry_d = mk_entry(REST_CODE, END_DUR);
        case (int'(addr_i))
            0: entry_d = mk_entry(8'd5, 8'd2);
            1: entry_d = mk_entry(REST_CODE, 8'd1);
            2: entry_d = mk_entry(8'd9, 8'd3);
            3: if (SONG_SEL == 1) entry_d = mk_entry(8'd7, 8'd1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        data_q <= entry_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks the song table, holding each note (note_code/play)
// for dur timebase ticks and inserting a silent gap between notes.
//   clk_i   : system clock
//   reset_i : synchronous, active-high
//   bus     : slave side of melody_sequencer_if (start/stop/loop_en in,
//             note_code/play/busy/done/note_idx out, all registered)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | silent, waiting for start
// ST_FETCH | table address presented
// ST_LOAD  | table entry valid; end marker or latch note and duration
// ST_NOTE  | note sounding (or rest), counting duration ticks
// ST_GAP   | silent gap after a note, note_code held
// ST_DONE  | one-cycle done pulse, then idle
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int TICK_CYCLES = 500_000,
    parameter int SONG_LEN    = 16,
    parameter int ADDR_W      = 4,
    parameter int GAP_TICKS   = 1,
    parameter int SONG_SEL    = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    melody_sequencer_if.slave   bus
);

    localparam int                PRESC_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [7:0]         GAP_INIT  = 8'(GAP_TICKS);
    localparam bit                 HAS_GAP   = (GAP_TICKS > 0);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PRESC_W-1:0] presc_q;
    logic [DUR_W-1:0]  remain_q;
    logic [7:0]        gap_q;
    logic [NOTE_W-1:0] note_code_q;
    logic              play_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] note_idx_q;

    song_entry_t rom_data;

    logic tick_wrap;
    logic note_end;
    logic gap_end;
    logic advance;
    logic song_end;

    melody_rom #(
        .ADDR_W   (ADDR_W),
        .SONG_SEL (SONG_SEL)
    ) u_rom (
        .clk_i  (clk_i),
        .addr_i (addr_q),
        .data_o (rom_data)
    );

    // advance: the timed part of an entry is over, move to the next address.
    // song_end: end marker seen, or advance off the last table entry.
    always_comb begin
        tick_wrap = (presc_q == PRESC_MAX);
        note_end  = (state_q == ST_NOTE) && tick_wrap && (remain_q == 8'd1);
        gap_end   = (state_q == ST_GAP) && tick_wrap && (gap_q == 8'd1);
        advance   = (note_end && !HAS_GAP) || gap_end;
        song_end  = ((state_q == ST_LOAD) && (rom_data.dur == END_DUR)) ||
                    (advance && (addr_q == LAST_ADDR));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            presc_q     <= '0;
            remain_q    <= '0;
            gap_q       <= '0;
            note_code_q <= REST_CODE;
            play_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            note_idx_q  <= '0;
        end else begin
            done_q <= 1'b0;
            // Prescaler only runs while timing a note or gap; it is zero on
            // entry to either, so every phase starts on a fresh tick.
            if ((state_q == ST_NOTE) || (state_q == ST_GAP))
                presc_q <= tick_wrap ? '0 : presc_q + 1'b1;
            else
                presc_q <= '0;

            if ((state_q != ST_IDLE) && bus.stop) begin
                state_q     <= ST_IDLE;
                play_q      <= 1'b0;
                note_code_q <= REST_CODE;
                busy_q      <= 1'b0;
            end else if (song_end) begin
                play_q <= 1'b0;
                if (bus.loop_en) begin
                    addr_q  <= '0;
                    state_q <= ST_FETCH;
                end else begin
                    state_q     <= ST_DONE;
                    done_q      <= 1'b1;
                    note_code_q <= REST_CODE;
                end
            end else if (advance) begin
                addr_q  <= addr_q + ADDR_W'(1);
                play_q  <= 1'b0;
                state_q <= ST_FETCH;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            addr_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                    ST_FETCH: state_q <= ST_LOAD;
                    ST_LOAD: begin
                        note_code_q <= rom_data.note;
                        play_q      <= (rom_data.note != REST_CODE);
                        note_idx_q  <= addr_q;
                        remain_q    <= rom_data.dur;
                        state_q     <= ST_NOTE;
                    end
                    ST_NOTE: begin
                        if (tick_wrap) remain_q <= remain_q - 8'd1;
                        if (note_end) begin
                            play_q  <= 1'b0;
                            gap_q   <= GAP_INIT;
                            state_q <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (tick_wrap) gap_q <= gap_q - 8'd1;
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.note_code = note_code_q;
    assign bus.play      = play_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.note_idx  = note_idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer. DUT A: demo song {5,2},{0,1},{9,3},END in a
// 16-entry table. DUT B: 4-entry table {5,2},{0,1},{9,3},{7,1} with no end
// marker. Both with TICK_CYCLES=4, GAP_TICKS=1. A monitor turns play/done
// pulses into events; scenarios push expected events as they start the song.
module tb_melody_sequencer;
    import melody_sequencer_pkg::*;

    typedef struct packed {
        logic        kind;    // 0 = play pulse, 1 = done pulse
        logic [7:0]  code;
        logic [3:0]  idx;
        logic [31:0] t_rise;
        logic [31:0] t_fall;
    } ev_t;

    localparam int TICK = 4;
    localparam int BIG  = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    ev_t exp_q[2][$];
    ev_t act_q[2][$];
    logic prev_play[2];
    logic prev_done[2];
    ev_t  cur_p[2];
    ev_t  cur_d[2];

    melody_sequencer_if #(.ADDR_W(4)) bus_a ();
    melody_sequencer_if #(.ADDR_W(2)) bus_b ();

    melody_sequencer #(.TICK_CYCLES(4), .SONG_LEN(16), .ADDR_W(4), .GAP_TICKS(1), .SONG_SEL(0))
        u_dut_a (.clk_i(clk), .reset_i(reset), .bus(bus_a));
    melody_sequencer #(.TICK_CYCLES(4), .SONG_LEN(4), .ADDR_W(2), .GAP_TICKS(1), .SONG_SEL(1))
        u_dut_b (.clk_i(clk), .reset_i(reset), .bus(bus_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic sample(input int g, input logic play, input logic done,
                          input logic [7:0] code, input logic [3:0] idx);
        if (play === 1'b1 && prev_play[g] !== 1'b1) begin
            cur_p[g] = '{kind: 1'b0, code: code, idx: idx, t_rise: 32'(cyc), t_fall: 32'd0};
        end
        if (play === 1'b0 && prev_play[g] === 1'b1) begin
            cur_p[g].t_fall = 32'(cyc);
            act_q[g].push_back(cur_p[g]);
        end
        if (done === 1'b1 && prev_done[g] !== 1'b1) begin
            cur_d[g] = '{kind: 1'b1, code: 8'd0, idx: idx, t_rise: 32'(cyc), t_fall: 32'd0};
        end
        if (done === 1'b0 && prev_done[g] === 1'b1) begin
            cur_d[g].t_fall = 32'(cyc);
            act_q[g].push_back(cur_d[g]);
        end
        prev_play[g] = play;
        prev_done[g] = done;
    endtask

    always @(negedge clk) begin
        sample(0, bus_a.play, bus_a.done, bus_a.note_code, bus_a.note_idx);
        sample(1, bus_b.play, bus_b.done, bus_b.note_code, {2'b00, bus_b.note_idx});
    end

    function automatic logic [15:0] tb_entry(input int g, input int i);
        if (i == 0) return {8'd5, 8'd2};
        if (i == 1) return {8'd0, 8'd1};
        if (i == 2) return {8'd9, 8'd3};
        if (g == 1 && i == 3) return {8'd7, 8'd1};
        return 16'd0;
    endfunction

    // Expected events of one pass whose FETCH of entry 0 is at sample f.
    // Each entry: FETCH, LOAD, dur*TICK note cycles, TICK gap cycles.
    task automatic push_pass(input int g, input int f, input bit with_done,
                             input int cutoff, output int e_o);
        int t;
        int i;
        int last;
        int len;
        int d;
        bit fin;
        logic [15:0] ent;
        t = f; i = 0; last = 0; fin = 0; e_o = 0;
        len = (g == 1) ? 4 : 16;
        while (!fin) begin
            ent = tb_entry(g, i);
            d = int'(ent[7:0]);
            if (d == 0) begin
                e_o = t + 2;
                fin = 1;
            end else begin
                if (ent[15:8] != 8'd0 && t + 2 + TICK * d <= cutoff)
                    exp_q[g].push_back('{kind: 1'b0, code: ent[15:8], idx: 4'(i),
                                        t_rise: 32'(t + 2), t_fall: 32'(t + 2 + TICK * d)});
                last = i;
                t = t + 2 + TICK * d + TICK;
                if (i == len - 1) begin
                    e_o = t;
                    fin = 1;
                end else begin
                    i++;
                end
            end
        end
        if (with_done && e_o + 1 <= cutoff)
            exp_q[g].push_back('{kind: 1'b1, code: 8'd0, idx: 4'(last),
                                t_rise: 32'(e_o), t_fall: 32'(e_o + 1)});
    endtask

    task automatic do_start(input int g, output int s);
        if (g == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
        @(negedge clk);
        s = cyc;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic test_reset();
        int s;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_a.play, bus_a.busy, bus_a.done, bus_a.note_code, bus_a.note_idx} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want 0",
                     {bus_a.play, bus_a.busy, bus_a.done, bus_a.note_code, bus_a.note_idx});
        end else n_pass++;
        n_checks++;
        if ({bus_b.play, bus_b.busy, bus_b.done, bus_b.note_code, bus_b.note_idx} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0",
                     {bus_b.play, bus_b.busy, bus_b.done, bus_b.note_code, bus_b.note_idx});
        end else n_pass++;

        do_start(0, s);
        while (cyc < s + 30) @(negedge clk);
        n_checks++;
        if ({bus_a.play, bus_a.note_code, bus_a.note_idx} !== {1'b1, 8'd9, 4'd2}) begin
            n_fail++;
            $display("FAIL mid_note9: got %h want %h",
                     {bus_a.play, bus_a.note_code, bus_a.note_idx}, {1'b1, 8'd9, 4'd2});
        end else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({bus_a.play, bus_a.busy, bus_a.done, bus_a.note_code, bus_a.note_idx} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid_note: got %h want 0",
                     {bus_a.play, bus_a.busy, bus_a.done, bus_a.note_code, bus_a.note_idx});
        end else n_pass++;
        repeat (2) @(negedge clk);
        act_q[0].delete();
        exp_q[0].delete();
    endtask

    task automatic test_single_pass();
        int s, e, t_idle;
        ev_t ea, ee;
        bus_a.loop_en = 1'b0;
        do_start(0, s);
        push_pass(0, s, 1'b1, BIG, e);
        t_idle = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_a.busy === 1'b0) begin t_idle = cyc; break; end
        end
        n_checks++;
        if (t_idle !== e + 1) begin
            n_fail++;
            $display("FAIL single_busy_low: got %0d want %0d", t_idle - s, e + 1 - s);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (act_q[0].size() !== exp_q[0].size()) begin
            n_fail++;
            $display("FAIL single_evcount: got %0d want %0d", act_q[0].size(), exp_q[0].size());
        end else n_pass++;
        while (exp_q[0].size() > 0) begin
            ee = exp_q[0].pop_front();
            ea = (act_q[0].size() > 0) ? act_q[0].pop_front() : '0;
            n_checks++;
            if (ea !== ee) begin
                n_fail++;
                $display("FAIL single_ev: got %h want %h", ea, ee);
            end else n_pass++;
        end
        act_q[0].delete();
    endtask

    task automatic test_loop();
        int s, e1, e2, e3;
        ev_t ea, ee;
        bus_a.loop_en = 1'b1;
        do_start(0, s);
        push_pass(0, s, 1'b0, BIG, e1);
        push_pass(0, e1, 1'b0, BIG, e2);
        push_pass(0, e2, 1'b0, s + 104, e3);
        while (cyc < s + 104) @(negedge clk);
        n_checks++;
        if (bus_a.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_busy: got %b want 1", bus_a.busy);
        end else n_pass++;
        bus_a.stop = 1'b1;
        @(negedge clk);
        bus_a.stop = 1'b0;
        bus_a.loop_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (act_q[0].size() !== exp_q[0].size()) begin
            n_fail++;
            $display("FAIL loop_evcount: got %0d want %0d", act_q[0].size(), exp_q[0].size());
        end else n_pass++;
        while (exp_q[0].size() > 0) begin
            ee = exp_q[0].pop_front();
            ea = (act_q[0].size() > 0) ? act_q[0].pop_front() : '0;
            n_checks++;
            if (ea !== ee) begin
                n_fail++;
                $display("FAIL loop_ev: got %h want %h", ea, ee);
            end else n_pass++;
        end
        act_q[0].delete();
    endtask

    task automatic test_stop();
        int s, e, t_idle;
        ev_t ea, ee;
        bus_a.loop_en = 1'b0;
        do_start(0, s);
        exp_q[0].push_back('{kind: 1'b0, code: 8'd5, idx: 4'd0, t_rise: 32'(s + 2), t_fall: 32'(s + 10)});
        exp_q[0].push_back('{kind: 1'b0, code: 8'd9, idx: 4'd2, t_rise: 32'(s + 26), t_fall: 32'(s + 31)});
        while (cyc < s + 30) @(negedge clk);
        bus_a.stop = 1'b1;
        @(negedge clk);
        bus_a.stop = 1'b0;
        n_checks++;
        if ({bus_a.play, bus_a.busy, bus_a.done, bus_a.note_code} !== 11'd0) begin
            n_fail++;
            $display("FAIL stop_outputs: got %h want 0",
                     {bus_a.play, bus_a.busy, bus_a.done, bus_a.note_code});
        end else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (act_q[0].size() !== exp_q[0].size()) begin
            n_fail++;
            $display("FAIL stop_evcount: got %0d want %0d", act_q[0].size(), exp_q[0].size());
        end else n_pass++;
        while (exp_q[0].size() > 0) begin
            ee = exp_q[0].pop_front();
            ea = (act_q[0].size() > 0) ? act_q[0].pop_front() : '0;
            n_checks++;
            if (ea !== ee) begin
                n_fail++;
                $display("FAIL stop_ev: got %h want %h", ea, ee);
            end else n_pass++;
        end
        act_q[0].delete();

        do_start(0, s);
        push_pass(0, s, 1'b1, BIG, e);
        t_idle = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_a.busy === 1'b0) begin t_idle = cyc; break; end
        end
        @(negedge clk);
        n_checks++;
        if (t_idle !== e + 1) begin
            n_fail++;
            $display("FAIL restart_busy_low: got %0d want %0d", t_idle - s, e + 1 - s);
        end else n_pass++;
        while (exp_q[0].size() > 0) begin
            ee = exp_q[0].pop_front();
            ea = (act_q[0].size() > 0) ? act_q[0].pop_front() : '0;
            n_checks++;
            if (ea !== ee) begin
                n_fail++;
                $display("FAIL restart_ev: got %h want %h", ea, ee);
            end else n_pass++;
        end
        act_q[0].delete();
    endtask

    task automatic test_start_ignored();
        int s, e, t_idle;
        logic seen_busy;
        ev_t ea, ee;
        bus_a.loop_en = 1'b0;
        do_start(0, s);
        push_pass(0, s, 1'b1, BIG, e);
        while (cyc < s + 5) @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_a.play, bus_a.note_code, bus_a.note_idx} !== {1'b1, 8'd5, 4'd0}) begin
            n_fail++;
            $display("FAIL busy_start_note: got %h want %h",
                     {bus_a.play, bus_a.note_code, bus_a.note_idx}, {1'b1, 8'd5, 4'd0});
        end else n_pass++;
        t_idle = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_a.busy === 1'b0) begin t_idle = cyc; break; end
        end
        @(negedge clk);
        n_checks++;
        if (t_idle !== e + 1) begin
            n_fail++;
            $display("FAIL busy_start_len: got %0d want %0d", t_idle - s, e + 1 - s);
        end else n_pass++;
        while (exp_q[0].size() > 0) begin
            ee = exp_q[0].pop_front();
            ea = (act_q[0].size() > 0) ? act_q[0].pop_front() : '0;
            n_checks++;
            if (ea !== ee) begin
                n_fail++;
                $display("FAIL busy_start_ev: got %h want %h", ea, ee);
            end else n_pass++;
        end
        act_q[0].delete();

        bus_a.start = 1'b1;
        bus_a.stop  = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.stop  = 1'b0;
        seen_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus_a.busy !== 1'b0 || bus_a.play !== 1'b0) seen_busy = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen_busy !== 1'b0 || act_q[0].size() !== 0) begin
            n_fail++;
            $display("FAIL start_stop_same: got busy %b events %0d want 0 0",
                     seen_busy, act_q[0].size());
        end else n_pass++;
        act_q[0].delete();
    endtask

    task automatic test_no_end();
        int s, e, e2, t_idle;
        ev_t ea, ee;
        bus_b.loop_en = 1'b0;
        do_start(1, s);
        push_pass(1, s, 1'b1, BIG, e);
        t_idle = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_b.busy === 1'b0) begin t_idle = cyc; break; end
        end
        @(negedge clk);
        n_checks++;
        if (t_idle !== e + 1) begin
            n_fail++;
            $display("FAIL noend_busy_low: got %0d want %0d", t_idle - s, e + 1 - s);
        end else n_pass++;
        n_checks++;
        if (act_q[1].size() !== exp_q[1].size()) begin
            n_fail++;
            $display("FAIL noend_evcount: got %0d want %0d", act_q[1].size(), exp_q[1].size());
        end else n_pass++;
        while (exp_q[1].size() > 0) begin
            ee = exp_q[1].pop_front();
            ea = (act_q[1].size() > 0) ? act_q[1].pop_front() : '0;
            n_checks++;
            if (ea !== ee) begin
                n_fail++;
                $display("FAIL noend_ev: got %h want %h", ea, ee);
            end else n_pass++;
        end
        act_q[1].delete();

        bus_b.loop_en = 1'b1;
        do_start(1, s);
        push_pass(1, s, 1'b0, BIG, e);
        push_pass(1, e, 1'b0, e + 12, e2);
        while (cyc < e + 12) @(negedge clk);
        bus_b.stop = 1'b1;
        @(negedge clk);
        bus_b.stop = 1'b0;
        bus_b.loop_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (act_q[1].size() !== exp_q[1].size() || bus_b.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL noend_loop_evcount: got %0d busy %b want %0d busy 0",
                     act_q[1].size(), bus_b.busy, exp_q[1].size());
        end else n_pass++;
        while (exp_q[1].size() > 0) begin
            ee = exp_q[1].pop_front();
            ea = (act_q[1].size() > 0) ? act_q[1].pop_front() : '0;
            n_checks++;
            if (ea !== ee) begin
                n_fail++;
                $display("FAIL noend_loop_ev: got %h want %h", ea, ee);
            end else n_pass++;
        end
        act_q[1].delete();
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.loop_en = 1'b0;
        bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.loop_en = 1'b0;
        prev_play = '{1'b0, 1'b0};
        prev_done = '{1'b0, 1'b0};
        test_reset();
        test_single_pass();
        test_loop();
        test_stop();
        test_start_ignored();
        test_no_end();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
